branch_predictor: RTL and testbench

Parametrised branch prediction unit for the 5-stage MIPS pipeline, replacing the valid+PC direct-mapped BTB. Each entry holds valid, tag, saturating direction counter and target. The table is looked up with the IF PC and returns a registered prediction aligned with the instruction memory output in ID. It is trained from WB with the resolved branch outcome. After reset it runs a hardware init sweep and keeps lookup/mispredict statistics.

---
 rtl/branch_predictor.sv | 180 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: valid/tag/saturating-counter/target table,
// registered lookup from IF, training from WB, power-on valid sweep and statistics.
module branch_predictor #(
   parameter int IDX_W = 10,
   parameter int TAG_W = 8,
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lk_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        busy,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_branch,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_miss,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_miss
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 ** CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(2 ** (CNT_W - 1));
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

   logic [0:0]       state_r;
   logic [IDX_W-1:0] ptr_r;
   logic             busy_r;
   logic             pred_taken_r;
   logic [31:0]      pred_target_r;
   logic [31:0]      stat_lookups_r;
   logic [31:0]      stat_miss_r;

   // Table storage; only valid is swept, the other fields are overwritten on allocate
   logic [DEPTH-1:0] valid_r;
   logic [TAG_W-1:0] tag_r    [DEPTH];
   logic [CNT_W-1:0] cnt_r    [DEPTH];
   logic [31:0]      target_r [DEPTH];

   logic             run_s;
   logic [IDX_W-1:0] lk_idx_s;
   logic [TAG_W-1:0] lk_tag_s;
   logic             lk_hit_s;
   logic [IDX_W-1:0] up_idx_s;
   logic [TAG_W-1:0] up_tag_s;
   logic             up_hit_s;
   logic [CNT_W-1:0] up_cnt_s;
   logic             we_s;
   logic             wr_valid_s;
   logic [CNT_W-1:0] wr_cnt_s;
   logic [31:0]      wr_target_s;
   logic             unused_pc_bits_s;

   assign run_s    = (state_r == ST_RUN);
   assign lk_idx_s = lk_pc[2 +: IDX_W];
   assign lk_tag_s = lk_pc[2 + IDX_W +: TAG_W];
   assign up_idx_s = upd_pc[2 +: IDX_W];
   assign up_tag_s = upd_pc[2 + IDX_W +: TAG_W];
   assign lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
   assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
   assign up_cnt_s = cnt_r[up_idx_s];
   assign unused_pc_bits_s = ^{lk_pc, upd_pc};

   // Training decision for the entry addressed by upd_pc
   always_comb begin
      we_s        = 1'b0;
      wr_valid_s  = 1'b0;
      wr_cnt_s    = up_cnt_s;
      wr_target_s = target_r[up_idx_s];
      if (run_s && upd_valid) begin
         if (upd_is_branch) begin
            if (up_hit_s) begin
               we_s       = 1'b1;
               wr_valid_s = 1'b1;
               if (upd_taken) begin
                  wr_cnt_s    = (up_cnt_s == CNT_MAX) ? up_cnt_s : up_cnt_s + CNT_W'(1);
                  wr_target_s = upd_target;
               end else begin
                  wr_cnt_s = (up_cnt_s == CNT_ZERO) ? up_cnt_s : up_cnt_s - CNT_W'(1);
               end
            end else if (upd_taken) begin
               we_s        = 1'b1;
               wr_valid_s  = 1'b1;
               wr_cnt_s    = CNT_WEAK;
               wr_target_s = upd_target;
            end else begin
               we_s = 1'b0;
            end
         end else if (up_hit_s) begin
            // A non-branch matching the tag is an alias: drop the entry
            we_s       = 1'b1;
            wr_valid_s = 1'b0;
         end else begin
            we_s = 1'b0;
         end
      end else begin
         we_s = 1'b0;
      end
   end

   // Table write port: valid sweep during INIT, training writes during RUN
   always_ff @(posedge clk) begin
      if (!run_s) begin
         valid_r[ptr_r] <= 1'b0;
      end else if (we_s) begin
         valid_r[up_idx_s]  <= wr_valid_s;
         tag_r[up_idx_s]    <= up_tag_s;
         cnt_r[up_idx_s]    <= wr_cnt_s;
         target_r[up_idx_s] <= wr_target_s;
      end
   end

   // Sweep sequencer and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_INIT;
         ptr_r   <= {IDX_W{1'b0}};
         busy_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (ptr_r == PTR_LAST) begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b0;
               end else begin
                  ptr_r <= ptr_r + IDX_W'(1);
               end
            end
            ST_RUN: begin
               busy_r <= 1'b0;
            end
            default: begin
               state_r <= ST_INIT;
               ptr_r   <= {IDX_W{1'b0}};
               busy_r  <= 1'b1;
            end
         endcase
      end
   end

   // Registered prediction, read before any same-cycle training write lands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_taken_r  <= 1'b0;
         pred_target_r <= 32'h0000_0000;
      end else if (run_s) begin
         pred_taken_r  <= lk_hit_s && cnt_r[lk_idx_s][CNT_W-1];
         pred_target_r <= lk_hit_s ? target_r[lk_idx_s] : 32'h0000_0000;
      end else begin
         pred_taken_r  <= 1'b0;
         pred_target_r <= 32'h0000_0000;
      end
   end

   // Statistics, frozen while sweeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_lookups_r <= 32'd0;
         stat_miss_r    <= 32'd0;
      end else if (run_s) begin
         stat_lookups_r <= stat_lookups_r + 32'd1;
         if (upd_valid && upd_miss) begin
            stat_miss_r <= stat_miss_r + 32'd1;
         end
      end
   end

   assign pred_taken   = pred_taken_r;
   assign pred_target  = pred_target_r;
   assign busy         = busy_r;
   assign stat_lookups = stat_lookups_r;
   assign stat_miss    = stat_miss_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor at IDX_W=4, TAG_W=8, CNT_W=2.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lk_pc = 32'h0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        busy;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = 32'h0;
   logic        upd_is_branch = 1'b0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = 32'h0;
   logic        upd_miss = 1'b0;
   logic [31:0] stat_lookups;
   logic [31:0] stat_miss;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.IDX_W(4), .TAG_W(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .lk_pc(lk_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .busy(busy),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_miss(upd_miss),
      .stat_lookups(stat_lookups), .stat_miss(stat_miss)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ub;
      logic        ut;
      logic [31:0] utgt;
      logic        um;
      logic [31:0] lpc;
      logic        et;
      logic [31:0] etgt;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ub,
                               input logic ut, input logic [31:0] utgt, input logic um,
                               input logic [31:0] lpc, input logic et, input logic [31:0] etgt);
      vec_t r;
      r.uv = uv; r.upc = upc; r.ub = ub; r.ut = ut; r.utgt = utgt; r.um = um;
      r.lpc = lpc; r.et = et; r.etgt = etgt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      upd_valid = v.uv; upd_pc = v.upc; upd_is_branch = v.ub;
      upd_taken = v.ut; upd_target = v.utgt; upd_miss = v.um; lk_pc = v.lpc;
   endtask

   task automatic idle_lookup(input logic [31:0] pc);
      upd_valid = 1'b0; upd_miss = 1'b0; lk_pc = pc;
      @(posedge clk); #1;
   endtask

   // Walks the 16-entry sweep right after rst falls
   task automatic sweep_check(input logic [31:0] miss_exp);
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         chk($sformatf("sweep_busy[%0d]", i), {31'b0, busy}, {31'b0, (i < 16)});
         chk($sformatf("sweep_pred[%0d]", i), {31'b0, pred_taken}, 32'h0);
         chk($sformatf("sweep_lookups[%0d]", i), stat_lookups, 32'h0);
         chk($sformatf("sweep_miss[%0d]", i), stat_miss, miss_exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // index = pc[5:2], tag = pc[13:6]; 0x40 and 0x80 share index 0
      vecs[0]  = mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 32'h100);
      vecs[2]  = mk(1'b1, 32'h40, 1'b1, 1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 32'h100);
      vecs[3]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 1'b0, 32'h100);
      vecs[4]  = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h80, 1'b0, 32'h0);
      vecs[5]  = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h80, 1'b1, 32'h200);
      vecs[6]  = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h80, 1'b1, 32'h200);
      vecs[7]  = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h80, 1'b1, 32'h200);
      vecs[8]  = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h204, 1'b0, 32'h80, 1'b1, 32'h200);
      vecs[9]  = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   1'b1, 32'h80, 1'b1, 32'h204);
      vecs[10] = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   1'b0, 32'h80, 1'b1, 32'h204);
      vecs[11] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h204);
      vecs[12] = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h204);
      vecs[13] = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h204);
      vecs[14] = mk(1'b1, 32'h80, 1'b1, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h204);
      vecs[15] = mk(1'b1, 32'h80, 1'b1, 1'b1, 32'h204, 1'b0, 32'h80, 1'b0, 32'h204);
      vecs[16] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h204);
      vecs[17] = mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h300, 1'b0, 32'h40, 1'b0, 32'h0);
      vecs[18] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h80, 1'b0, 32'h0);
      vecs[19] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 32'h300);
      vecs[20] = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 1'b1, 32'h300);
      vecs[21] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h40, 1'b0, 32'h0);
      vecs[22] = mk(1'b1, 32'h48, 1'b1, 1'b0, 32'h500, 1'b0, 32'h48, 1'b0, 32'h0);
      vecs[23] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h48, 1'b0, 32'h0);
      vecs[24] = mk(1'b1, 32'h44, 1'b1, 1'b1, 32'h444, 1'b0, 32'h44, 1'b0, 32'h0);
      vecs[25] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h44, 1'b1, 32'h444);

      // Reset values while rst is held
      @(posedge clk); #1;
      chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
      chk("rst_pred_target", pred_target, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);
      chk("rst_lookups", stat_lookups, 32'h0);
      chk("rst_miss", stat_miss, 32'h0);

      // Updates and miss reports during the sweep must be ignored
      rst = 1'b0;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_is_branch = 1'b1;
      upd_taken = 1'b1; upd_target = 32'h999; upd_miss = 1'b1; lk_pc = 32'h40;
      sweep_check(32'h0);

      for (int i = 0; i < 26; i++) begin
         drive(vecs[i]);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].et});
         chk($sformatf("vec%0d_target", i), pred_target, vecs[i].etgt);
      end
      chk("run_lookups", stat_lookups, 32'd26);
      chk("run_miss", stat_miss, 32'd2);
      chk("run_busy", {31'b0, busy}, 32'h0);

      // Train 0x4C with three flagged mispredictions, then reset asynchronously
      for (int i = 0; i < 3; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h4C; upd_is_branch = 1'b1;
         upd_taken = 1'b1; upd_target = 32'h4C0; upd_miss = 1'b1; lk_pc = 32'h0;
         @(posedge clk); #1;
      end
      idle_lookup(32'h4C);
      chk("pre_rst_taken_4c", {31'b0, pred_taken}, 32'h1);
      chk("pre_rst_miss", stat_miss, 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_lookups", stat_lookups, 32'h0);
      chk("async_rst_miss", stat_miss, 32'h0);
      chk("async_rst_busy", {31'b0, busy}, 32'h1);
      chk("async_rst_pred", {31'b0, pred_taken}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      upd_valid = 1'b0; upd_miss = 1'b0; lk_pc = 32'h44;
      sweep_check(32'h0);

      idle_lookup(32'h44);
      chk("post_rst_taken_44", {31'b0, pred_taken}, 32'h0);
      chk("post_rst_target_44", pred_target, 32'h0);
      idle_lookup(32'h4C);
      chk("post_rst_taken_4c", {31'b0, pred_taken}, 32'h0);
      idle_lookup(32'h40);
      chk("post_rst_taken_40", {31'b0, pred_taken}, 32'h0);
      chk("post_rst_lookups", stat_lookups, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
